// File: rtl/divider_8bit_pkg.sv
// Shared types and constants for the 8-bit restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } div_state_t;

    localparam int         DIV_WIDTH = 8;
    localparam int         DIV_STEPS = 8;
    localparam logic [6:0] HEX_ZERO  = 7'b1000000;

endpackage

// File: rtl/divider_8bit_if.sv
// Board-side bundle for the divider: switch/button inputs, result and display outputs.
interface divider_8bit_if;
    import div_pkg::*;

    logic                 Run;
    logic                 LoadD;
    logic [DIV_WIDTH-1:0] S;
    logic [DIV_WIDTH-1:0] Quotient;
    logic [DIV_WIDTH-1:0] Remainder;
    logic                 Done;
    logic                 DivZero;
    logic [6:0]           Qhex0;
    logic [6:0]           Qhex1;
    logic [6:0]           Rhex0;
    logic [6:0]           Rhex1;

    modport master (
        output Run, LoadD, S,
        input  Quotient, Remainder, Done, DivZero, Qhex0, Qhex1, Rhex0, Rhex1
    );

    modport slave (
        input  Run, LoadD, S,
        output Quotient, Remainder, Done, DivZero, Qhex0, Qhex1, Rhex0, Rhex1
    );

endinterface

// File: rtl/divider_8bit_sub_9.sv
// 9-bit ripple-borrow subtractor: Diff = A - B, Borrow set when A < B.
module sub_9 (
    input  logic [8:0] A,
    input  logic [8:0] B,
    output logic [8:0] Diff,
    output logic       Borrow
);

    logic [9:0] bw_s;

    assign bw_s[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < 9; i++) begin : g_fs
            assign Diff[i]   = A[i] ^ B[i] ^ bw_s[i];
            assign bw_s[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bw_s[i]);
        end
    endgenerate

    assign Borrow = bw_s[9];

endmodule

// File: rtl/hex_driver.sv
// Nibble to active-low 7-segment pattern, segment order {g,f,e,d,c,b,a}.
module HexDriver (
    input  logic [3:0] In0,
    output logic [6:0] Out0
);

    // Segment lookup for one hex digit
    always_comb begin
        Out0 = 7'b1111111;
        case (In0)
            4'h0:    Out0 = 7'b1000000;
            4'h1:    Out0 = 7'b1111001;
            4'h2:    Out0 = 7'b0100100;
            4'h3:    Out0 = 7'b0110000;
            4'h4:    Out0 = 7'b0011001;
            4'h5:    Out0 = 7'b0010010;
            4'h6:    Out0 = 7'b0000010;
            4'h7:    Out0 = 7'b1111000;
            4'h8:    Out0 = 7'b0000000;
            4'h9:    Out0 = 7'b0010000;
            4'hA:    Out0 = 7'b0001000;
            4'hB:    Out0 = 7'b0000011;
            4'hC:    Out0 = 7'b1000110;
            4'hD:    Out0 = 7'b0100001;
            4'hE:    Out0 = 7'b0000110;
            4'hF:    Out0 = 7'b0001110;
            default: Out0 = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/divider_8bit.sv
// Unsigned restoring shift-subtract divider: one quotient bit per cycle over 8 cycles,
// with registered result, status and hex display outputs.
module divider_8bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic           Clk,
    input  logic           Reset,
    divider_8bit_if.slave  bus
);

    div_state_t       state_r, state_s;
    logic [WIDTH-1:0] quotient_r, remainder_r, divisor_r;
    logic [2:0]       count_r;
    logic             done_r, div_zero_r;
    logic             load_div_s, start_s, step_s, done_s;
    logic [8:0]       trial_s;
    logic             borrow_s, trial_msb_unused_s;
    logic [6:0]       qhex0_s, qhex1_s, rhex0_s, rhex1_s;
    logic [6:0]       qhex0_r, qhex1_r, rhex0_r, rhex1_r;

    sub_9 u_sub (
        .A      ({remainder_r, quotient_r[WIDTH-1]}),
        .B      ({1'b0, divisor_r}),
        .Diff   (trial_s),
        .Borrow (borrow_s)
    );

    assign trial_msb_unused_s = trial_s[8];

    // FSM state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; LoadD outranks Run, and a held Run parks in DONE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.LoadD)    state_s = IDLE;
                else if (bus.Run) state_s = COMPUTE;
                else              state_s = IDLE;
            end
            COMPUTE: begin
                if (count_r == 3'(DIV_STEPS - 1)) state_s = DONE;
                else                              state_s = COMPUTE;
            end
            DONE: begin
                if (bus.LoadD)     state_s = DONE;
                else if (!bus.Run) state_s = IDLE;
                else               state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM output decode into datapath controls
    always_comb begin
        load_div_s = 1'b0;
        start_s    = 1'b0;
        step_s     = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                load_div_s = bus.LoadD;
                start_s    = ~bus.LoadD & bus.Run;
            end
            COMPUTE: begin
                step_s = 1'b1;
            end
            DONE: begin
                load_div_s = bus.LoadD;
                done_s     = 1'b1;
            end
            default: begin
                load_div_s = 1'b0;
            end
        endcase
    end

    // Divisor, quotient/remainder shift pair and step counter
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            divisor_r   <= {WIDTH{1'b0}};
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            count_r     <= 3'd0;
            div_zero_r  <= 1'b0;
        end else begin
            if (load_div_s) begin
                divisor_r <= bus.S;
            end
            if (start_s) begin
                quotient_r  <= bus.S;
                remainder_r <= {WIDTH{1'b0}};
                count_r     <= 3'd0;
                div_zero_r  <= (divisor_r == {WIDTH{1'b0}});
            end else if (step_s) begin
                // Restore on borrow by keeping the plain shifted remainder
                if (borrow_s) begin
                    remainder_r <= {remainder_r[WIDTH-2:0], quotient_r[WIDTH-1]};
                    quotient_r  <= {quotient_r[WIDTH-2:0], 1'b0};
                end else begin
                    remainder_r <= trial_s[WIDTH-1:0];
                    quotient_r  <= {quotient_r[WIDTH-2:0], 1'b1};
                end
                count_r <= count_r + 3'd1;
            end
        end
    end

    HexDriver u_qhex0 (.In0(quotient_r[3:0]),  .Out0(qhex0_s));
    HexDriver u_qhex1 (.In0(quotient_r[7:4]),  .Out0(qhex1_s));
    HexDriver u_rhex0 (.In0(remainder_r[3:0]), .Out0(rhex0_s));
    HexDriver u_rhex1 (.In0(remainder_r[7:4]), .Out0(rhex1_s));

    // Done flag and hex digits, one register stage behind the datapath
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            done_r  <= 1'b0;
            qhex0_r <= HEX_ZERO;
            qhex1_r <= HEX_ZERO;
            rhex0_r <= HEX_ZERO;
            rhex1_r <= HEX_ZERO;
        end else begin
            done_r  <= done_s;
            qhex0_r <= qhex0_s;
            qhex1_r <= qhex1_s;
            rhex0_r <= rhex0_s;
            rhex1_r <= rhex1_s;
        end
    end

    assign bus.Quotient  = quotient_r;
    assign bus.Remainder = remainder_r;
    assign bus.Done      = done_r;
    assign bus.DivZero   = div_zero_r;
    assign bus.Qhex0     = qhex0_r;
    assign bus.Qhex1     = qhex1_r;
    assign bus.Rhex0     = rhex0_r;
    assign bus.Rhex1     = rhex1_r;

endmodule

// File: tb/tb_divider_8bit.sv
// Scoreboard bench for divider_8bit: expected quotient/remainder queued at launch, checked at Done.
module tb_divider_8bit;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 Clk = ~Clk;

    divider_8bit_if dif ();

    divider_8bit #(.WIDTH(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (dif)
    );

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.a  = a;
        e.d  = d;
        e.dz = (d == 8'd0);
        if (d == 8'd0) begin
            e.q = 8'hFF;
            e.r = a;
        end else begin
            e.q = a / d;
            e.r = a % d;
        end
        return e;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  4'hF: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic launch(input logic [7:0] d, input logic [7:0] a);
        @(negedge Clk);
        dif.S     = d;
        dif.LoadD = 1'b1;
        @(negedge Clk);
        dif.LoadD = 1'b0;
        dif.S     = a;
        dif.Run   = 1'b1;
        sb.push_back(model(a, d));
    endtask

    task automatic start_only(input logic [7:0] a, input logic [7:0] d_held);
        @(negedge Clk);
        dif.S   = a;
        dif.Run = 1'b1;
        sb.push_back(model(a, d_held));
    endtask

    // Counts falling edges until Done is seen; returns 40 if it never comes
    task automatic wait_done(input bit hold, output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge Clk);
            cyc++;
            if (!hold) dif.Run = 1'b0;
            if (dif.Done === 1'b1) break;
        end
    endtask

    task automatic test_reset;
        Reset     = 1'b0;
        dif.Run   = 1'b0;
        dif.LoadD = 1'b0;
        dif.S     = 8'd0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        vectors++;
        if ({dif.Quotient, dif.Remainder, dif.Done, dif.DivZero} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_regs: got q=%h r=%h done=%b dz=%b, want all 0",
                     dif.Quotient, dif.Remainder, dif.Done, dif.DivZero);
        end
        vectors++;
        if ({dif.Qhex1, dif.Qhex0, dif.Rhex1, dif.Rhex0} !== {4{7'b1000000}}) begin
            miscompares++;
            $display("FAIL reset_hex: got %b %b %b %b, want 1000000 x4",
                     dif.Qhex1, dif.Qhex0, dif.Rhex1, dif.Rhex0);
        end
    endtask

    task automatic test_basic;
        int   cyc;
        exp_t e;
        launch(8'd7, 8'd200);
        wait_done(1'b0, cyc);
        e = sb.pop_front();
        vectors++;
        if (cyc !== 10) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d, want 10", cyc);
        end
        vectors++;
        if (dif.Quotient !== e.q || dif.Remainder !== e.r || dif.DivZero !== e.dz) begin
            miscompares++;
            $display("FAIL basic_result: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                     dif.Quotient, dif.Remainder, dif.DivZero, e.q, e.r, e.dz);
        end
        @(negedge Clk);
        vectors++;
        if ({dif.Qhex1, dif.Qhex0, dif.Rhex1, dif.Rhex0} !==
            {seg7(e.q[7:4]), seg7(e.q[3:0]), seg7(e.r[7:4]), seg7(e.r[3:0])}) begin
            miscompares++;
            $display("FAIL basic_hex: got %b %b %b %b, want digits %h %h",
                     dif.Qhex1, dif.Qhex0, dif.Rhex1, dif.Rhex0, e.q, e.r);
        end
    endtask

    task automatic test_edge_cases;
        logic [7:0] ds [3];
        logic [7:0] as [3];
        int         cyc;
        exp_t       e;
        ds[0] = 8'd1;  as[0] = 8'd255;
        ds[1] = 8'd10; as[1] = 8'd3;
        ds[2] = 8'd0;  as[2] = 8'd5;
        for (int i = 0; i < 3; i++) begin
            launch(ds[i], as[i]);
            wait_done(1'b0, cyc);
            e = sb.pop_front();
            vectors++;
            if (cyc !== 10 || dif.Quotient !== e.q || dif.Remainder !== e.r ||
                dif.DivZero !== e.dz) begin
                miscompares++;
                $display("FAIL edge_%0d: got lat=%0d q=%h r=%h dz=%b, want lat=10 q=%h r=%h dz=%b",
                         i, cyc, dif.Quotient, dif.Remainder, dif.DivZero, e.q, e.r, e.dz);
            end
        end
    endtask

    task automatic test_hold_run;
        int   cyc;
        int   rises;
        logic prev;
        exp_t e;
        launch(8'd12, 8'd99);
        wait_done(1'b1, cyc);
        e     = sb.pop_front();
        rises = (dif.Done === 1'b1) ? 1 : 0;
        prev  = dif.Done;
        repeat (30) begin
            @(negedge Clk);
            if (dif.Done === 1'b1 && prev !== 1'b1) rises++;
            prev = dif.Done;
        end
        vectors++;
        if (rises !== 1 || dif.Done !== 1'b1 || dif.Quotient !== e.q || dif.Remainder !== e.r) begin
            miscompares++;
            $display("FAIL hold_run: got rises=%0d done=%b q=%h r=%h, want rises=1 done=1 q=%h r=%h",
                     rises, dif.Done, dif.Quotient, dif.Remainder, e.q, e.r);
        end
        dif.Run = 1'b0;
        repeat (3) @(negedge Clk);
        vectors++;
        if (dif.Done !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release: got done=%b, want 0", dif.Done);
        end
    endtask

    task automatic test_loadd_in_compute;
        int   cyc;
        exp_t e;
        launch(8'd9, 8'd100);
        @(negedge Clk);
        dif.Run = 1'b0;
        @(negedge Clk);
        dif.S     = 8'd3;
        dif.LoadD = 1'b1;
        @(negedge Clk);
        dif.LoadD = 1'b0;
        wait_done(1'b0, cyc);
        e = sb.pop_front();
        vectors++;
        if (cyc !== 7 || dif.Quotient !== e.q || dif.Remainder !== e.r) begin
            miscompares++;
            $display("FAIL loadd_compute: got lat=%0d q=%h r=%h, want lat=7 q=%h r=%h",
                     cyc, dif.Quotient, dif.Remainder, e.q, e.r);
        end
        start_only(8'd100, 8'd9);
        wait_done(1'b0, cyc);
        e = sb.pop_front();
        vectors++;
        if (dif.Quotient !== e.q || dif.Remainder !== e.r) begin
            miscompares++;
            $display("FAIL divisor_kept: got q=%h r=%h, want q=%h r=%h",
                     dif.Quotient, dif.Remainder, e.q, e.r);
        end
    endtask

    task automatic test_loadd_and_run;
        int   cyc;
        exp_t e;
        @(negedge Clk);
        dif.S     = 8'd6;
        dif.LoadD = 1'b1;
        dif.Run   = 1'b1;
        @(negedge Clk);
        dif.LoadD = 1'b0;
        dif.S     = 8'd50;
        sb.push_back(model(8'd50, 8'd6));
        wait_done(1'b0, cyc);
        e = sb.pop_front();
        vectors++;
        if (cyc !== 10 || dif.Quotient !== e.q || dif.Remainder !== e.r) begin
            miscompares++;
            $display("FAIL loadd_priority: got lat=%0d q=%h r=%h, want lat=10 q=%h r=%h",
                     cyc, dif.Quotient, dif.Remainder, e.q, e.r);
        end
    endtask

    task automatic test_reset_mid;
        int   cyc;
        exp_t e;
        launch(8'd0, 8'd77);
        @(negedge Clk);
        dif.Run = 1'b0;
        repeat (3) @(negedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        sb.delete();
        vectors++;
        if ({dif.Quotient, dif.Remainder, dif.Done, dif.DivZero} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_async: got q=%h r=%h done=%b dz=%b, want all 0",
                     dif.Quotient, dif.Remainder, dif.Done, dif.DivZero);
        end
        @(posedge Clk);
        @(negedge Clk);
        vectors++;
        if ({dif.Qhex1, dif.Qhex0, dif.Rhex1, dif.Rhex0} !== {4{7'b1000000}} ||
            dif.Done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_hex: got %b %b %b %b done=%b, want 1000000 x4 done=0",
                     dif.Qhex1, dif.Qhex0, dif.Rhex1, dif.Rhex0, dif.Done);
        end
        Reset = 1'b1;
        start_only(8'd77, 8'd0);
        wait_done(1'b0, cyc);
        e = sb.pop_front();
        vectors++;
        if (cyc !== 10 || dif.Quotient !== e.q || dif.Remainder !== e.r || dif.DivZero !== e.dz) begin
            miscompares++;
            $display("FAIL after_reset_zero: got lat=%0d q=%h r=%h dz=%b, want lat=10 q=%h r=%h dz=%b",
                     cyc, dif.Quotient, dif.Remainder, dif.DivZero, e.q, e.r, e.dz);
        end
        launch(8'd5, 8'd77);
        wait_done(1'b0, cyc);
        e = sb.pop_front();
        vectors++;
        if (dif.Quotient !== e.q || dif.Remainder !== e.r || dif.DivZero !== e.dz) begin
            miscompares++;
            $display("FAIL after_reset_div: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                     dif.Quotient, dif.Remainder, dif.DivZero, e.q, e.r, e.dz);
        end
    endtask

    task automatic test_random;
        int         cyc;
        exp_t       e;
        logic [7:0] a;
        logic [7:0] d;
        bit         ident_ok;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            if (i % 16 == 0) a = 8'hFF;
            if (i % 16 == 1) a = 8'h00;
            if (i % 16 == 2) d = 8'h00;
            if (i % 16 == 3) d = 8'hFF;
            launch(d, a);
            wait_done(1'b0, cyc);
            e = sb.pop_front();
            ident_ok = (e.d == 8'd0) ||
                       ((int'(dif.Quotient) * int'(e.d) + int'(dif.Remainder) == int'(e.a)) &&
                        (dif.Remainder < e.d));
            vectors++;
            if (cyc !== 10 || dif.Quotient !== e.q || dif.Remainder !== e.r ||
                dif.DivZero !== e.dz || !ident_ok) begin
                miscompares++;
                $display("FAIL random_%0d: %h/%h got lat=%0d q=%h r=%h dz=%b, want lat=10 q=%h r=%h dz=%b",
                         i, e.a, e.d, cyc, dif.Quotient, dif.Remainder, dif.DivZero, e.q, e.r, e.dz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge_cases();
        test_hold_run();
        test_loadd_in_compute();
        test_loadd_and_run();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/divider_8bit.md
Name: divider_8bit

Overview:
- Unsigned 8-bit restoring shift-subtract divider for the board lab datapath; inverse of the shift-add multiplier.
- Divisor is loaded from slider switches S with LoadD. Run latches the dividend from S and computes quotient and remainder over 8 shift cycles.
- Results drive LEDs and four registered 7-segment hex displays.
- Contains a 9-bit subtractor sub-module.

Parameters:
- WIDTH, 8, operand width. Only 8 is supported because the hex display wiring is fixed to 8 bits.

Ports:
- Clk  input  1  system clock, 50 MHz.
- Reset  input  1  asynchronous, active-low reset.
- Run  input  1  active-high level, synchronized upstream; starts a divide.
- LoadD  input  1  active-high level, synchronized upstream; loads divisor from S.
- S  input  8  slider switches; dividend or divisor value.
- Quotient  output  8  quotient register.
- Remainder  output  8  remainder register.
- Done  output  1  result valid; high in DONE state.
- DivZero  output  1  last operation had divisor == 0.
- Qhex0, Qhex1  output  7 each  hex digits of Quotient, low/high nibble; active-low segments.
- Rhex0, Rhex1  output  7 each  hex digits of Remainder, low/high nibble; active-low segments.

Behaviour:
- Reset (asynchronous, active-low) clears:
  - Quotient, Remainder, divisor register, cycle count, Done and DivZero to 0;
  - state to IDLE;
  - all hex registers to 7'b1000000 (digit "0").
- Reset asserted mid-operation aborts the operation with the same values; no partial result is retained.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - LoadD=1: divisor <= S. LoadD has priority over Run; Run is ignored that cycle.
  - Otherwise Run=1: Quotient <= S, Remainder <= 0, count <= 0, DivZero <= (divisor==0), go to COMPUTE.
- COMPUTE (one step per cycle, 8 cycles):
  - trial = {Remainder, Quotient[7]} - {1'b0, divisor}, a 9-bit subtraction with borrow.
  - No borrow: Remainder <= trial[7:0], Quotient <= {Quotient[6:0], 1}.
  - Borrow: Remainder <= {Remainder[6:0], Quotient[7]}, Quotient <= {Quotient[6:0], 0}.
  - count increments each cycle; after the 8th step (count==7) go to DONE.
  - Run and LoadD are ignored in this state.
- DONE:
  - Done=1; Quotient and Remainder hold.
  - LoadD=1 loads the divisor and stays in DONE.
  - Run=0 returns to IDLE.
  - A held Run never causes a second operation; Run must fall, then rise again.
- Latency: Run sampled high at edge k gives final results and Done=1 after edge k+9.
- Divide by zero: runs the full 8 steps unchanged, which naturally yields Quotient=FF and Remainder=dividend; DivZero=1.
- Remainder is always less than the divisor when divisor != 0; Quotient*divisor + Remainder == dividend.
- Hex outputs are registered one cycle after Quotient/Remainder so they stay off the critical path.

Decomposition:
- Package div_pkg holds:
  - state enum div_state_t {IDLE, COMPUTE, DONE};
  - constant DIV_WIDTH=8;
  - constant DIV_STEPS=8;
  - constant HEX_ZERO=7'b1000000.
- Sub-module sub_9: combinational 9-bit A - B, outputs Diff[8:0] and Borrow. Built ripple-style, in the same style as the team's ripple adder.
- Hex digits use the existing HexDriver.

Test Plan:
- Load divisor 7, Run with S=200 (C8) -> Done rises 9 cycles after Run; Quotient=28 (1C), Remainder=4, DivZero=0; Qhex shows "1C" one cycle later.
- Divisor 1, dividend 255 -> Quotient=FF, Remainder=00. Divisor 10, dividend 3 -> Quotient=00, Remainder=03.
- Divisor 0, dividend 5 -> Quotient=FF, Remainder=05, DivZero=1, latency still 9 cycles.
- Hold Run high for 30 cycles -> exactly one operation. LoadD pulsed with S=3 during COMPUTE -> divisor unchanged and result unaffected. LoadD and Run high together in IDLE -> divisor loads, computation starts the following cycle.
- Assert Reset low at the 4th COMPUTE cycle -> Quotient, Remainder, Done and DivZero are 0 immediately (asynchronous), state is IDLE, hex shows "00" after the clock; a fresh Run then divides correctly.
- Random sweep of 1000 dividend/divisor pairs including 0 and FF -> Quotient*divisor + Remainder == dividend and Remainder < divisor when divisor != 0.
